attn_score_stream: RTL

Streaming, parameterised score stage for the attention pipeline. It buffers one sequence of K tokens, then accepts Q tokens one at a time. For each Q row it emits the scaled dot-product score S[row][col] = (Q[row]·K[col]) >> SCALE_SHIFT, one element per handshake. It uses a single time-multiplexed MAC and has an optional causal mask. It replaces the fully parallel, flat-bus stage-1 score computation so that larger TOKEN_NUM/TOKEN_DIM fit in area.

---
 rtl/attn_score_stream_if.sv | 47 ++++
 rtl/attn_score_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/attn_score_stream_if.sv
// ---------------------------------------------------------------------------
// attn_score_stream_if
//   Handshake bundle for the streaming attention score stage.
//   master : producer of K/Q tokens and consumer of scores (upstream/downstream)
//   slave  : the score stage itself
//
//   causal            causal-mask mode, sampled with the first K beat
//   k_valid/k_ready   K token handshake, k_data = TOKEN_DIM packed elements
//   q_valid/q_ready   Q token handshake, q_data packed like k_data
//   s_valid/s_ready   score handshake
//   s_data            scaled, saturated score
//   s_row/s_col       score index
//   s_masked          score forced to 0 by the causal mask
//   s_last            final score of the sequence
// ---------------------------------------------------------------------------
interface attn_score_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TOKEN_DIM  = 4,
    parameter int TOKEN_NUM  = 8
);
    localparam int IDX_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;

    logic                            causal;
    logic                            k_valid;
    logic                            k_ready;
    logic [DATA_WIDTH*TOKEN_DIM-1:0] k_data;
    logic                            q_valid;
    logic                            q_ready;
    logic [DATA_WIDTH*TOKEN_DIM-1:0] q_data;
    logic                            s_valid;
    logic                            s_ready;
    logic [DATA_WIDTH-1:0]           s_data;
    logic [IDX_W-1:0]                s_row;
    logic [IDX_W-1:0]                s_col;
    logic                            s_masked;
    logic                            s_last;

    modport master (
        output causal, k_valid, k_data, q_valid, q_data, s_ready,
        input  k_ready, q_ready, s_valid, s_data, s_row, s_col, s_masked, s_last
    );

    modport slave (
        input  causal, k_valid, k_data, q_valid, q_data, s_ready,
        output k_ready, q_ready, s_valid, s_data, s_row, s_col, s_masked, s_last
    );
endinterface

// File: rtl/attn_score_stream.sv
// ---------------------------------------------------------------------------
// attn_score_stream
//   Buffers one sequence of TOKEN_NUM K tokens, then takes Q tokens one at a
//   time and streams S[row][col] = (Q[row].K[col]) >> SCALE_SHIFT, one score
//   per handshake, using a single time-multiplexed MAC. Optional causal mask
//   (col > row) forces a score to 0 without spending MAC cycles on it.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; also gates all ready/valid outputs
//     bus    attn_score_stream_if.slave (K/Q token inputs, score output)
// ---------------------------------------------------------------------------
module attn_score_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int TOKEN_DIM   = 4,
    parameter int TOKEN_NUM   = 8,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    attn_score_stream_if.slave  bus
);
    localparam int IDX_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
    localparam int D_W   = (TOKEN_DIM > 1) ? $clog2(TOKEN_DIM) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Sum of TOKEN_DIM full-width products cannot overflow this width.
    localparam int ACC_W = PROD_W + $clog2(TOKEN_DIM);
    localparam int SHIFT = FRAC_BITS + SCALE_SHIFT;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOKEN_NUM - 1);
    localparam logic [D_W-1:0]   D_LAST   = D_W'(TOKEN_DIM - 1);

    typedef enum logic [1:0] {LOAD_K, WAIT_Q, CALC, OUT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      row;
        logic [IDX_W-1:0]      col;
        logic                  masked;
        logic                  last;
    } score_t;

    typedef logic [TOKEN_DIM-1:0][DATA_WIDTH-1:0] token_t;

    state_t state, state_nxt;

    token_t           kbuf [TOKEN_NUM];
    token_t           qreg;
    logic [IDX_W-1:0] k_cnt;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [D_W-1:0]   d;
    logic [ACC_W-1:0] acc;
    logic             causal_l;
    score_t           score_q;

    logic k_fire, q_fire, s_fire;
    logic k_ready_w, q_ready_w, s_valid_w;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_sum;
    logic [IDX_W-1:0]  col_inc;
    logic              next_masked;

    assign k_fire = bus.k_valid && k_ready_w;
    assign q_fire = bus.q_valid && q_ready_w;
    assign s_fire = s_valid_w && bus.s_ready;

    // Single MAC: one dimension of the current (row, col) pair per CALC cycle.
    assign prod    = PROD_W'(qreg[d]) * PROD_W'(kbuf[col][d]);
    assign acc_sum = acc + ACC_W'(prod);

    // Mask decision for the column that follows the score being handed off.
    assign col_inc     = col + IDX_W'(1);
    assign next_masked = causal_l && (col_inc > row);

    // Drop the fraction and the 1/sqrt(d) shift, then clamp to the data range.
    function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] sh;
        sh = a >> SHIFT;
        if (|sh[ACC_W-1:DATA_WIDTH]) scale_sat = '1;
        else                         scale_sat = sh[DATA_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD_K;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and handshake decode. Readies/valid depend only on the
    // registered state; rst_n holds them low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        k_ready_w = 1'b0;
        q_ready_w = 1'b0;
        s_valid_w = 1'b0;
        if (rst_n) begin
            unique case (state)
                LOAD_K: k_ready_w = 1'b1;
                WAIT_Q: q_ready_w = 1'b1;
                OUT:    s_valid_w = 1'b1;
                default: ;
            endcase
        end
        unique case (state)
            LOAD_K: if (k_fire && k_cnt == IDX_LAST) state_nxt = WAIT_Q;
            // Column 0 can never satisfy col > row, so a new row always computes.
            WAIT_Q: if (q_fire) state_nxt = CALC;
            CALC:   if (d == D_LAST) state_nxt = OUT;
            OUT: begin
                if (s_fire) begin
                    if (col != IDX_LAST)      state_nxt = next_masked ? OUT : CALC;
                    else if (row != IDX_LAST) state_nxt = WAIT_Q;
                    else                      state_nxt = LOAD_K;
                end
            end
            default: state_nxt = LOAD_K;
        endcase
    end

    // ------------------------------------------------------------------
    // Token storage. Contents are don't-care until rewritten, so no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && state == LOAD_K && k_fire) kbuf[k_cnt] <= bus.k_data;
        if (rst_n && state == WAIT_Q && q_fire) qreg <= bus.q_data;
    end

    // ------------------------------------------------------------------
    // Counters, accumulator and registered score
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_cnt    <= '0;
            row      <= '0;
            col      <= '0;
            d        <= '0;
            acc      <= '0;
            causal_l <= 1'b0;
            score_q  <= '0;
        end else begin
            unique case (state)
                LOAD_K: begin
                    if (k_fire) begin
                        if (k_cnt == '0) causal_l <= bus.causal;
                        if (k_cnt == IDX_LAST) begin
                            k_cnt <= '0;
                            row   <= '0;
                        end else begin
                            k_cnt <= k_cnt + IDX_W'(1);
                        end
                    end
                end
                WAIT_Q: begin
                    if (q_fire) begin
                        col <= '0;
                        acc <= '0;
                        d   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    if (d == D_LAST) begin
                        d            <= '0;
                        // Last product is folded in here so the score is ready
                        // on the same edge the FSM enters OUT.
                        score_q.data   <= scale_sat(acc_sum);
                        score_q.row    <= row;
                        score_q.col    <= col;
                        score_q.masked <= 1'b0;
                        score_q.last   <= (row == IDX_LAST) && (col == IDX_LAST);
                    end else begin
                        d <= d + D_W'(1);
                    end
                end
                OUT: begin
                    if (s_fire) begin
                        if (col != IDX_LAST) begin
                            col <= col_inc;
                            acc <= '0;
                            d   <= '0;
                            // A masked score skips CALC, so load it directly.
                            if (next_masked) begin
                                score_q.data   <= '0;
                                score_q.row    <= row;
                                score_q.col    <= col_inc;
                                score_q.masked <= 1'b1;
                                score_q.last   <= (row == IDX_LAST) && (col_inc == IDX_LAST);
                            end
                        end else if (row != IDX_LAST) begin
                            row <= row + IDX_W'(1);
                        end else begin
                            row <= '0;
                            col <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.k_ready  = k_ready_w;
    assign bus.q_ready  = q_ready_w;
    assign bus.s_valid  = s_valid_w;
    assign bus.s_data   = score_q.data;
    assign bus.s_row    = score_q.row;
    assign bus.s_col    = score_q.col;
    assign bus.s_masked = score_q.masked;
    assign bus.s_last   = score_q.last;
endmodule
